// File: rtl/zanagotchi_pkg.sv
// zanagotchi_pkg: shared button FSM states and board clock constant
package zanagotchi_pkg;
  localparam int CLK_HZ = 27_000_000;
  typedef enum logic [2:0] {SOLTO, DEB_PRESS, PRESSIONADO, SEGURANDO, DEB_SOLTA} estado_t;
endpackage

// File: rtl/canal_botao.sv
// canal_botao: synchroniser, debounce FSM, hold and auto-repeat timers for one button
module canal_botao import zanagotchi_pkg::*; #(
  parameter int DEBOUNCE_CICLOS = 270000,
  parameter int HOLD_CICLOS     = 27000000,
  parameter int REPEAT_CICLOS   = 5400000,
  parameter int ATIVO_BAIXO     = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic b_i,
  output logic nivel_o,
  output logic nivel_d_o,
  output logic press_o,
  output logic release_o,
  output logic hold_o,
  output logic repeat_o
);
  localparam logic SOLTO_NIVEL = ATIVO_BAIXO != 0;
  localparam int DW = $clog2(DEBOUNCE_CICLOS) + 1;
  localparam int TW = $clog2(HOLD_CICLOS > REPEAT_CICLOS ? HOLD_CICLOS : REPEAT_CICLOS) + 1;
  logic [1:0] sync_q;
  estado_t st_q;
  logic [DW-1:0] deb_q;
  logic [TW-1:0] tmr_q;
  logic nivel_q, press_q, release_q, hold_q, repeat_q;
  logic ativo, deb_cheio, press_w, rel_w;
  logic [DW-1:0] deb_inc;
  logic [TW-1:0] tmr_inc;
  assign ativo     = sync_q[1] ^ SOLTO_NIVEL;
  assign deb_cheio = deb_q >= DW'(DEBOUNCE_CICLOS);
  assign deb_inc   = deb_q + DW'(~&deb_q);
  assign tmr_inc   = tmr_q + TW'(~&tmr_q);
  assign press_w   = st_q == DEB_PRESS && ativo && deb_cheio;
  assign rel_w     = st_q == DEB_SOLTA && !ativo && deb_cheio;
  assign nivel_d_o = rst_n && (press_w || (nivel_q && !rel_w));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q    <= {2{SOLTO_NIVEL}};
      st_q      <= SOLTO;
      deb_q     <= '0;
      tmr_q     <= '0;
      nivel_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      hold_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], b_i};
      nivel_q   <= press_w || (nivel_q && !rel_w);
      press_q   <= press_w;
      release_q <= rel_w;
      repeat_q  <= 1'b0;
      case (st_q)
        SOLTO: if (ativo) begin
          st_q  <= DEB_PRESS;
          deb_q <= DW'(1);
        end
        DEB_PRESS: if (!ativo) begin
          st_q  <= SOLTO;
          deb_q <= '0;
        end else if (deb_cheio) begin
          st_q  <= PRESSIONADO;
          deb_q <= '0;
          tmr_q <= '0;
        end else deb_q <= deb_inc;
        PRESSIONADO: if (!ativo) begin
          st_q  <= DEB_SOLTA;
          deb_q <= DW'(1);
        end else if (tmr_q >= TW'(HOLD_CICLOS - 1)) begin
          st_q     <= SEGURANDO;
          hold_q   <= 1'b1;
          repeat_q <= 1'b1;
          tmr_q    <= '0;
        end else tmr_q <= tmr_inc;
        SEGURANDO: if (!ativo) begin
          st_q  <= DEB_SOLTA;
          deb_q <= DW'(1);
        end else if (tmr_q >= TW'(REPEAT_CICLOS - 1)) begin
          repeat_q <= 1'b1;
          tmr_q    <= '0;
        end else tmr_q <= tmr_inc;
        // a bounce back to pressed resumes the frozen hold/repeat timer
        DEB_SOLTA: if (ativo) begin
          st_q  <= hold_q ? SEGURANDO : PRESSIONADO;
          deb_q <= '0;
        end else if (deb_cheio) begin
          st_q   <= SOLTO;
          deb_q  <= '0;
          hold_q <= 1'b0;
        end else deb_q <= deb_inc;
        default: st_q <= SOLTO;
      endcase
    end
  end
  assign nivel_o   = nivel_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign hold_o    = hold_q;
  assign repeat_o  = repeat_q;
endmodule

// File: rtl/controlador_botoes_multi.sv
// controlador_botoes_multi: N debounced button channels plus an all-pressed combo pulse
module controlador_botoes_multi import zanagotchi_pkg::*; #(
  parameter int N_BOTOES        = 2,
  parameter int DEBOUNCE_CICLOS = CLK_HZ / 100,
  parameter int HOLD_CICLOS     = CLK_HZ,
  parameter int REPEAT_CICLOS   = CLK_HZ / 5,
  parameter int ATIVO_BAIXO     = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_BOTOES-1:0] b_in,
  output logic [N_BOTOES-1:0] b_nivel,
  output logic [N_BOTOES-1:0] b_press,
  output logic [N_BOTOES-1:0] b_release,
  output logic [N_BOTOES-1:0] b_hold,
  output logic [N_BOTOES-1:0] b_repeat,
  output logic                b_combo
);
  logic [N_BOTOES-1:0] nivel_d;
  logic b_combo_q;
  for (genvar i = 0; i < N_BOTOES; i++) begin : g_canal
    canal_botao #(
      .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS),
      .HOLD_CICLOS(HOLD_CICLOS),
      .REPEAT_CICLOS(REPEAT_CICLOS),
      .ATIVO_BAIXO(ATIVO_BAIXO)
    ) u_canal (
      .clk(clk),
      .rst_n(rst_n),
      .b_i(b_in[i]),
      .nivel_o(b_nivel[i]),
      .nivel_d_o(nivel_d[i]),
      .press_o(b_press[i]),
      .release_o(b_release[i]),
      .hold_o(b_hold[i]),
      .repeat_o(b_repeat[i])
    );
  end
  // looks at next-state levels so the combo lands on the same cycle as the press
  always_ff @(posedge clk) b_combo_q <= rst_n && (&nivel_d) && !(&b_nivel);
  assign b_combo = b_combo_q;
endmodule

// File: tb/tb_controlador_botoes_multi.sv
// tb_controlador_botoes_multi: scoreboard bench with hand-timed expected output events
module tb_controlador_botoes_multi;
  typedef struct packed {
    int       cyc;
    logic [1:0] press, rel, rep;
    logic       combo;
    logic [1:0] hold, nivel;
  } ev_t;

  logic clk = 0, rst_n;
  logic [1:0] b_in, b_nivel, b_press, b_release, b_hold, b_repeat;
  logic b_combo;
  int ec = 0, pass = 0, total = 0, t0, p, s;
  bit started = 0;
  logic [3:0] prev;
  ev_t q[$];
  ev_t obs, e;

  controlador_botoes_multi #(
    .N_BOTOES(2), .DEBOUNCE_CICLOS(4), .HOLD_CICLOS(20), .REPEAT_CICLOS(5), .ATIVO_BAIXO(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .b_in(b_in), .b_nivel(b_nivel), .b_press(b_press),
    .b_release(b_release), .b_hold(b_hold), .b_repeat(b_repeat), .b_combo(b_combo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ec <= ec + 1;

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", n, got, exp, ec);
  endtask

  task automatic exp_ev(input int c, input logic [1:0] pr, input logic [1:0] rl, input logic [1:0] rp,
                        input logic cb, input logic [1:0] h, input logic [1:0] n);
    q.push_back('{cyc: c, press: pr, rel: rl, rep: rp, combo: cb, hold: h, nivel: n});
  endtask

  task automatic wait_to(input int k);
    while (ec < k) @(negedge clk);
  endtask

  always @(negedge clk) begin
    obs = '{cyc: ec, press: b_press, rel: b_release, rep: b_repeat, combo: b_combo, hold: b_hold, nivel: b_nivel};
    if (started && (|b_press || |b_release || |b_repeat || b_combo || {b_hold, b_nivel} != prev)) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_event: got %h expected none", obs);
      end else begin
        e = q.pop_front();
        chk("event", 64'(obs), 64'(e));
      end
    end
    prev = {b_hold, b_nivel};
  end

  initial begin
    rst_n = 0;
    b_in = 2'b11;
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk("reset_state", {b_nivel, b_press, b_release, b_hold, b_repeat, b_combo}, 0);
    started = 1;
    b_in[0] = 0; repeat (1) @(negedge clk);
    b_in[0] = 1; repeat (2) @(negedge clk);
    b_in[0] = 0; repeat (3) @(negedge clk);
    b_in[0] = 1; repeat (1) @(negedge clk);
    b_in[0] = 0; repeat (4) @(negedge clk);
    b_in[0] = 1; repeat (10) @(negedge clk);
    chk("bounce_nivel", b_nivel, 0);
    t0 = ec;
    p = t0 + 7;
    b_in[0] = 0;
    exp_ev(p, 2'b01, 0, 0, 0, 2'b00, 2'b01);
    for (int k = 20; k <= 35; k += 5) exp_ev(p + k, 0, 0, 2'b01, 0, 2'b01, 2'b01);
    exp_ev(p + 44, 0, 0, 2'b01, 0, 2'b01, 2'b01);
    exp_ev(p + 49, 0, 2'b01, 0, 0, 2'b00, 2'b00);
    wait_to(p + 36); b_in[0] = 1;
    wait_to(p + 39); b_in[0] = 0;
    wait_to(p + 42); b_in[0] = 1;
    wait_to(p + 52);
    s = ec;
    b_in = 2'b00;
    exp_ev(s + 7, 2'b11, 0, 0, 1, 2'b00, 2'b11);
    exp_ev(s + 15, 0, 2'b10, 0, 0, 2'b00, 2'b01);
    exp_ev(s + 23, 2'b10, 0, 0, 1, 2'b00, 2'b11);
    exp_ev(s + 27, 0, 0, 2'b01, 0, 2'b01, 2'b11);
    exp_ev(s + 30, 0, 0, 0, 0, 2'b00, 2'b00);
    exp_ev(s + 37, 2'b11, 0, 0, 1, 2'b00, 2'b11);
    wait_to(s + 8); b_in[1] = 1;
    wait_to(s + 16); b_in[1] = 0;
    wait_to(s + 29); rst_n = 0;
    wait_to(s + 30); rst_n = 1;
    chk("mid_hold_reset", {b_nivel, b_press, b_release, b_hold, b_repeat, b_combo}, 0);
    wait_to(s + 45);
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
